// File: rtl/mezclador_bandas_pkg.sv
// Shared widths, FSM encodings and saturation limits for the equaliser mix stage
// and the output stage that reuses the clamp.
package mezclador_bandas_pkg;

  localparam int DECIM = 14;
  localparam int MAGN  = 8;
  localparam int N     = DECIM + MAGN + 1;
  localparam int PROD_W = 2 * N;
  localparam int ACC_W  = 2 * N + 2;

  localparam logic [N-1:0] SAT_MAX = 23'h3FFFFF;
  localparam logic [N-1:0] SAT_MIN = 23'h400000;

  // Clamp limits sign-extended to accumulator width
  localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MAC_B = 3'd1,
    MAC_M = 3'd2,
    MAC_A = 3'd3,
    SAT   = 3'd4
  } estado_t;

endpackage

// File: rtl/mezclador_bandas_saturador.sv
// Combinational clamp of a wide signed accumulator into the N-bit sample range.
module saturador
  import mezclador_bandas_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc_in,
  output logic        [N-1:0]     dato_sat
);

  always_comb begin
    if (acc_in > ACC_MAX)
      dato_sat = SAT_MAX;
    else if (acc_in < ACC_MIN)
      dato_sat = SAT_MIN;
    else
      dato_sat = acc_in[N-1:0];
  end

endmodule

// File: rtl/mezclador_bandas.sv
// Three-band gain/mix stage: one shared multiplier and accumulator step through
// bass, mid and treble, then the sum is clamped to the sample width.
//
// state | meaning
// IDLE  | waiting for sample_en; captures bands and gains
// MAC_B | accumulate bass product
// MAC_M | accumulate mid product
// MAC_A | accumulate treble product
// SAT   | clamp accumulator to dato_salida, pulse out_valid
module mezclador_bandas
  import mezclador_bandas_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         sample_en,
  input  logic [N-1:0] band_b,
  input  logic [N-1:0] band_m,
  input  logic [N-1:0] band_a,
  input  logic [N-1:0] gain_b,
  input  logic [N-1:0] gain_m,
  input  logic [N-1:0] gain_a,
  input  logic         overrun_clr,
  output logic [N-1:0] dato_salida,
  output logic         out_valid,
  output logic         busy,
  output logic         overrun
);

  estado_t estado, estado_sig;

  logic [N-1:0] band_b_q, band_m_q, band_a_q;
  logic [N-1:0] gain_b_q, gain_m_q, gain_a_q;
  logic signed [ACC_W-1:0] acc;

  logic signed [N-1:0]      op_band, op_gain;
  logic signed [PROD_W-1:0] producto;
  logic signed [ACC_W-1:0]  prod_ext, termino;
  logic        [N-1:0]      dato_sat;
  logic captura, acumula, satura;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= IDLE;
    else       estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    captura    = 1'b0;
    acumula    = 1'b0;
    satura     = 1'b0;
    op_band    = '0;
    op_gain    = '0;
    case (estado)
      IDLE: begin
        if (sample_en) begin
          captura    = 1'b1;
          estado_sig = MAC_B;
        end
      end
      MAC_B: begin
        acumula    = 1'b1;
        op_band    = band_b_q;
        op_gain    = gain_b_q;
        estado_sig = MAC_M;
      end
      MAC_M: begin
        acumula    = 1'b1;
        op_band    = band_m_q;
        op_gain    = gain_m_q;
        estado_sig = MAC_A;
      end
      MAC_A: begin
        acumula    = 1'b1;
        op_band    = band_a_q;
        op_gain    = gain_a_q;
        estado_sig = SAT;
      end
      SAT: begin
        satura     = 1'b1;
        estado_sig = IDLE;
      end
      default: estado_sig = IDLE;
    endcase
  end

  // Sign-extend before the arithmetic shift so the floor truncation survives
  assign producto = op_band * op_gain;
  assign prod_ext = {{(ACC_W-PROD_W){producto[PROD_W-1]}}, producto};
  assign termino  = prod_ext >>> DECIM;

  saturador u_saturador (
    .acc_in   (acc),
    .dato_sat (dato_sat)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      band_b_q    <= '0;
      band_m_q    <= '0;
      band_a_q    <= '0;
      gain_b_q    <= '0;
      gain_m_q    <= '0;
      gain_a_q    <= '0;
      acc         <= '0;
      dato_salida <= '0;
      out_valid   <= 1'b0;
    end else begin
      out_valid <= satura;
      if (captura) begin
        band_b_q <= band_b;
        band_m_q <= band_m;
        band_a_q <= band_a;
        gain_b_q <= gain_b;
        gain_m_q <= gain_m;
        gain_a_q <= gain_a;
        acc      <= '0;
      end else if (acumula) begin
        acc <= acc + termino;
      end
      if (satura) dato_salida <= dato_sat;
    end
  end

  assign busy = (estado != IDLE);

  // Set has priority over clear on the same edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                   overrun <= 1'b0;
    else if (sample_en && busy)  overrun <= 1'b1;
    else if (overrun_clr)        overrun <= 1'b0;
  end

endmodule
